// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and instruction field positions.
// The decode control unit slices instructions with the same field constants.
package fetch_stage_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_BUFWAIT = 3'd2,
    ST_DROP    = 3'd3,
    ST_HALTED  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, load captures a new
// instruction and PC+1, otherwise the contents hold.
module if_id_reg #(
  parameter int unsigned WORD_W = fetch_stage_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              flush,
  input  logic [WORD_W-1:0] inst_in,
  input  logic [WORD_W-1:0] pc1_in,
  output logic [WORD_W-1:0] inst,
  output logic [WORD_W-1:0] pc1,
  output logic              valid
);
  import fetch_stage_pkg::*;

  // Register update: reset, then flush, then load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      inst  <= {WORD_W{1'b0}};
      pc1   <= {WORD_W{1'b0}};
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      inst  <= inst_in;
      pc1   <= pc1_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, instruction-memory handshake, one-entry skid
// buffer for stalls, redirect/halt handling and the IF/ID register.
module fetch_stage #(
  parameter int unsigned       WORD_W   = fetch_stage_pkg::WORD_W,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              i_readM,
  output logic [WORD_W-1:0] i_address,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_ready,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_target,
  input  logic              halt,
  output logic [WORD_W-1:0] if_id_inst,
  output logic [WORD_W-1:0] if_id_pc1,
  output logic              if_id_valid,
  output logic [3:0]        opcode,
  output logic [5:0]        func_code
);
  import fetch_stage_pkg::*;

  fetch_state_t      state_r;
  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] buf_inst_r;
  logic [WORD_W-1:0] buf_pc1_r;
  logic              drop_to_halt_r;

  logic [WORD_W-1:0] pc_inc_s;
  logic              halt_go_s;
  logic              if_load_s;
  logic              if_flush_s;
  logic [WORD_W-1:0] if_inst_s;
  logic [WORD_W-1:0] if_pc1_s;

  assign pc_inc_s  = pc_r + WORD_W'(1);
  assign halt_go_s = halt & ~stall;

  // IF/ID control: what the register does this cycle, by state and event priority.
  always_comb begin
    if_load_s  = 1'b0;
    if_flush_s = 1'b0;
    if_inst_s  = i_data;
    if_pc1_s   = pc_inc_s;
    case (state_r)
      ST_FETCH: begin
        if (redirect_valid || halt_go_s) begin
          if_flush_s = 1'b1;
        end else if (stall) begin
          if_load_s = 1'b0;
        end else if (i_ready) begin
          if_load_s = 1'b1;
        end else begin
          if_flush_s = 1'b1;
        end
      end
      ST_BUFWAIT: begin
        if_inst_s = buf_inst_r;
        if_pc1_s  = buf_pc1_r;
        if (redirect_valid || halt_go_s) begin
          if_flush_s = 1'b1;
        end else if (stall) begin
          if_load_s = 1'b0;
        end else begin
          if_load_s = 1'b1;
        end
      end
      ST_IDLE, ST_DROP, ST_HALTED: begin
        if_flush_s = 1'b1;
      end
      default: begin
        if_flush_s = 1'b1;
      end
    endcase
  end

  // Fetch FSM with registered request outputs, PC and skid buffer.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r        <= ST_IDLE;
      pc_r           <= RESET_PC;
      i_readM        <= 1'b0;
      i_address      <= {WORD_W{1'b0}};
      buf_inst_r     <= {WORD_W{1'b0}};
      buf_pc1_r      <= {WORD_W{1'b0}};
      drop_to_halt_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (redirect_valid) begin
            pc_r      <= redirect_target;
            state_r   <= ST_FETCH;
            i_readM   <= 1'b1;
            i_address <= redirect_target;
          end else if (halt_go_s) begin
            state_r <= ST_HALTED;
          end else begin
            state_r   <= ST_FETCH;
            i_readM   <= 1'b1;
            i_address <= pc_r;
          end
        end
        ST_FETCH: begin
          if (redirect_valid) begin
            pc_r           <= redirect_target;
            drop_to_halt_r <= 1'b0;
            if (i_ready) begin
              i_address <= redirect_target;
            end else begin
              state_r <= ST_DROP;
            end
          end else if (halt_go_s) begin
            if (i_ready) begin
              state_r <= ST_HALTED;
              i_readM <= 1'b0;
            end else begin
              state_r        <= ST_DROP;
              drop_to_halt_r <= 1'b1;
            end
          end else if (i_ready) begin
            pc_r <= pc_inc_s;
            if (stall) begin
              // Park the returned word; the request stays idle until stall drops.
              buf_inst_r <= i_data;
              buf_pc1_r  <= pc_inc_s;
              state_r    <= ST_BUFWAIT;
              i_readM    <= 1'b0;
            end else begin
              i_address <= pc_inc_s;
            end
          end
        end
        ST_BUFWAIT: begin
          if (redirect_valid) begin
            pc_r      <= redirect_target;
            state_r   <= ST_FETCH;
            i_readM   <= 1'b1;
            i_address <= redirect_target;
          end else if (halt_go_s) begin
            state_r <= ST_HALTED;
          end else if (!stall) begin
            state_r   <= ST_FETCH;
            i_readM   <= 1'b1;
            i_address <= pc_r;
          end
        end
        ST_DROP: begin
          // The old request must finish on the bus before anything new issues.
          if (redirect_valid) begin
            pc_r           <= redirect_target;
            drop_to_halt_r <= 1'b0;
            if (i_ready) begin
              state_r   <= ST_FETCH;
              i_address <= redirect_target;
            end
          end else if (halt_go_s) begin
            drop_to_halt_r <= 1'b1;
            if (i_ready) begin
              state_r <= ST_HALTED;
              i_readM <= 1'b0;
            end
          end else if (i_ready) begin
            if (drop_to_halt_r) begin
              state_r <= ST_HALTED;
              i_readM <= 1'b0;
            end else begin
              state_r   <= ST_FETCH;
              i_address <= pc_r;
            end
          end
        end
        ST_HALTED: begin
          i_readM <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          i_readM <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .WORD_W (WORD_W)
  ) u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (if_load_s),
    .flush   (if_flush_s),
    .inst_in (if_inst_s),
    .pc1_in  (if_pc1_s),
    .inst    (if_id_inst),
    .pc1     (if_id_pc1),
    .valid   (if_id_valid)
  );

  assign opcode    = if_id_inst[OPCODE_MSB:OPCODE_LSB];
  assign func_code = if_id_inst[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small latency-configurable instruction memory.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        halt;
  logic [15:0] if_id_inst;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic [3:0]  opcode;
  logic [5:0]  func_code;

  int n_vec;
  int n_err;
  int lat;
  int wcnt;
  logic prev_readM;
  logic prev_ready;

  fetch_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_readM         (i_readM),
    .i_address       (i_address),
    .i_data          (i_data),
    .i_ready         (i_ready),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .if_id_inst      (if_id_inst),
    .if_id_pc1       (if_id_pc1),
    .if_id_valid     (if_id_valid),
    .opcode          (opcode),
    .func_code       (func_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish before it");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [15:0] r;
    case (a)
      16'h0000: r = 16'h4123;
      16'h0001: r = 16'hF01C;
      default:  r = a ^ 16'hA500;
    endcase
    return r;
  endfunction

  task automatic mem_eval();
    i_ready = i_readM && (wcnt == lat - 1);
    i_data  = i_ready ? mem(i_address) : 16'h0000;
  endtask

  // One clock: outputs and memory response are settled #1 after the rising edge.
  task automatic step();
    prev_readM = i_readM;
    prev_ready = i_ready;
    @(posedge clk);
    #1;
    if (!i_readM) wcnt = 0;
    else if (!prev_readM || prev_ready) wcnt = 0;
    else wcnt = wcnt + 1;
    mem_eval();
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_vec++; if (i_readM !== 1'b0) begin n_err++; $display("FAIL rst_readM got %b want 0", i_readM); end
    n_vec++; if (i_address !== 16'h0000) begin n_err++; $display("FAIL rst_addr got %h want 0000", i_address); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
    n_vec++; if (if_id_inst !== 16'h0000) begin n_err++; $display("FAIL rst_inst got %h want 0000", if_id_inst); end
    n_vec++; if (if_id_pc1 !== 16'h0000) begin n_err++; $display("FAIL rst_pc1 got %h want 0000", if_id_pc1); end
  endtask

  task automatic test_stream();
    reset_n = 1'b0;
    step();
    n_vec++; if (i_readM !== 1'b1) begin n_err++; $display("FAIL first_req got %b want 1", i_readM); end
    n_vec++; if (i_address !== 16'h0000) begin n_err++; $display("FAIL first_addr got %h want 0000", i_address); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL first_valid got %b want 0", if_id_valid); end
    step();
    n_vec++; if (if_id_inst !== 16'h4123) begin n_err++; $display("FAIL s1_inst got %h want 4123", if_id_inst); end
    n_vec++; if (if_id_pc1 !== 16'h0001) begin n_err++; $display("FAIL s1_pc1 got %h want 0001", if_id_pc1); end
    n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL s1_valid got %b want 1", if_id_valid); end
    n_vec++; if (opcode !== 4'd4) begin n_err++; $display("FAIL s1_opcode got %0d want 4", opcode); end
    n_vec++; if (func_code !== 6'd35) begin n_err++; $display("FAIL s1_func got %0d want 35", func_code); end
    n_vec++; if (i_address !== 16'h0001) begin n_err++; $display("FAIL s1_addr got %h want 0001", i_address); end
    step();
    n_vec++; if (if_id_inst !== 16'hF01C) begin n_err++; $display("FAIL s2_inst got %h want F01C", if_id_inst); end
    n_vec++; if (if_id_pc1 !== 16'h0002) begin n_err++; $display("FAIL s2_pc1 got %h want 0002", if_id_pc1); end
    n_vec++; if (opcode !== 4'd15) begin n_err++; $display("FAIL s2_opcode got %0d want 15", opcode); end
    n_vec++; if (func_code !== 6'd28) begin n_err++; $display("FAIL s2_func got %0d want 28", func_code); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (i_readM !== 1'b0) begin n_err++; $display("FAIL stall_readM[%0d] got %b want 0", i, i_readM); end
      n_vec++; if (if_id_inst !== 16'hF01C || if_id_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold[%0d] got %h/%b want F01C/1", i, if_id_inst, if_id_valid); end
    end
    stall = 1'b0;
    step();
    n_vec++; if (if_id_inst !== 16'hA502 || if_id_pc1 !== 16'h0003) begin
      n_err++; $display("FAIL unstall_buf got %h/%h want A502/0003", if_id_inst, if_id_pc1); end
    n_vec++; if (i_readM !== 1'b1 || i_address !== 16'h0003) begin
      n_err++; $display("FAIL unstall_req got %b/%h want 1/0003", i_readM, i_address); end
    step();
    n_vec++; if (if_id_inst !== 16'hA503 || if_id_pc1 !== 16'h0004 || if_id_valid !== 1'b1) begin
      n_err++; $display("FAIL after_stall got %h/%h/%b want A503/0004/1", if_id_inst, if_id_pc1, if_id_valid); end
  endtask

  task automatic test_redirect_drop();
    lat = 3;
    mem_eval();
    n_vec++; if (i_address !== 16'h0004 || i_ready !== 1'b0) begin
      n_err++; $display("FAIL rd_c0 got %h/%b want 0004/0", i_address, i_ready); end
    step();
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rd_bubble got %b want 0", if_id_valid); end
    redirect_valid = 1'b1; redirect_target = 16'h0040;
    step();
    redirect_valid = 1'b0;
    n_vec++; if (i_readM !== 1'b1 || i_address !== 16'h0004) begin
      n_err++; $display("FAIL rd_hold_addr got %b/%h want 1/0004", i_readM, i_address); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rd_drop_valid got %b want 0", if_id_valid); end
    step();
    n_vec++; if (i_readM !== 1'b1 || i_address !== 16'h0040) begin
      n_err++; $display("FAIL rd_target got %b/%h want 1/0040", i_readM, i_address); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rd_discard got %b want 0", if_id_valid); end
    step();
    step();
    step();
    n_vec++; if (if_id_inst !== 16'hA540 || if_id_pc1 !== 16'h0041 || if_id_valid !== 1'b1) begin
      n_err++; $display("FAIL rd_land got %h/%h/%b want A540/0041/1", if_id_inst, if_id_pc1, if_id_valid); end
  endtask

  task automatic test_redirect_halt();
    lat = 1;
    mem_eval();
    halt = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h0010;
    step();
    halt = 1'b0; redirect_valid = 1'b0;
    n_vec++; if (i_readM !== 1'b1 || i_address !== 16'h0010 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL rh_req got %b/%h/%b want 1/0010/0", i_readM, i_address, if_id_valid); end
    step();
    n_vec++; if (if_id_inst !== 16'hA510 || if_id_pc1 !== 16'h0011 || if_id_valid !== 1'b1) begin
      n_err++; $display("FAIL rh_land got %h/%h/%b want A510/0011/1", if_id_inst, if_id_pc1, if_id_valid); end
  endtask

  task automatic test_halt();
    halt = 1'b1;
    step();
    halt = 1'b0;
    for (int i = 0; i < 11; i++) begin
      n_vec++; if (i_readM !== 1'b0 || if_id_valid !== 1'b0) begin
        n_err++; $display("FAIL halted[%0d] got %b/%b want 0/0", i, i_readM, if_id_valid); end
      step();
    end
    reset_n = 1'b1;
    step();
    n_vec++; if (i_readM !== 1'b0 || i_address !== 16'h0000 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_rst got %b/%h/%b want 0/0000/0", i_readM, i_address, if_id_valid); end
    reset_n = 1'b0;
    step();
    n_vec++; if (i_readM !== 1'b1 || i_address !== 16'h0000) begin
      n_err++; $display("FAIL halt_restart got %b/%h want 1/0000", i_readM, i_address); end
  endtask

  task automatic test_halt_stall();
    step();
    halt = 1'b1; stall = 1'b1;
    step();
    halt = 1'b0; stall = 1'b0;
    mem_eval();
    n_vec++; if (i_readM !== 1'b0 || if_id_inst !== 16'h4123 || if_id_valid !== 1'b1) begin
      n_err++; $display("FAIL hs_hold got %b/%h/%b want 0/4123/1", i_readM, if_id_inst, if_id_valid); end
    step();
    n_vec++; if (if_id_inst !== 16'hF01C || if_id_pc1 !== 16'h0002 || i_address !== 16'h0002 || i_readM !== 1'b1) begin
      n_err++; $display("FAIL hs_resume got %h/%h/%h/%b want F01C/0002/0002/1", if_id_inst, if_id_pc1, i_address, i_readM); end
  endtask

  task automatic test_pc_wrap();
    redirect_valid = 1'b1; redirect_target = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    n_vec++; if (i_address !== 16'hFFFF) begin n_err++; $display("FAIL wrap_req got %h want FFFF", i_address); end
    step();
    n_vec++; if (if_id_pc1 !== 16'h0000 || if_id_inst !== 16'h5AFF || if_id_valid !== 1'b1) begin
      n_err++; $display("FAIL wrap_pc1 got %h/%h/%b want 0000/5AFF/1", if_id_pc1, if_id_inst, if_id_valid); end
    n_vec++; if (i_address !== 16'h0000 || i_readM !== 1'b1) begin
      n_err++; $display("FAIL wrap_next got %h/%b want 0000/1", i_address, i_readM); end
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 16'h0000;
    halt = 1'b0;
    i_ready = 1'b0;
    i_data = 16'h0000;
    n_vec = 0;
    n_err = 0;
    lat = 1;
    wcnt = 0;
    prev_readM = 1'b0;
    prev_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_halt();
    test_halt();
    test_halt_stall();
    test_pc_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 16-bit pipelined CPU.
- Sits directly upstream of the decode control unit:
  - drives its opcode and func_code inputs;
  - drives its is_available input through if_id_valid.
- Owns the PC and the instruction-memory read handshake, with a one-entry skid buffer for stalls.
- Handles redirects, flushes and halt.

Parameters:
- WORD_W, 16, instruction/PC width.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  clock; one clock domain.
- reset_n  in  1  one clock; reset is synchronous and active-high (asserted = 1, sampled on rising clk).
- i_readM  out  1  instruction-memory read request.
- i_address  out  WORD_W  read address; stable while i_readM is high.
- i_data  in  WORD_W  returned instruction; valid only when i_ready=1.
- i_ready  in  1  memory completes the outstanding read this cycle.
- stall  in  1  hazard unit: hold IF/ID and hold the PC.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_target  in  WORD_W  new PC.
- halt  in  1  decoded HLT in ID (already qualified by if_id_valid).
- if_id_inst  out  WORD_W  registered instruction.
- if_id_pc1  out  WORD_W  registered PC+1 of that instruction.
- if_id_valid  out  1  IF/ID holds a live instruction (drives is_available).
- opcode  out  4  if_id_inst[15:12].
- func_code  out  6  if_id_inst[5:0].

Behaviour:
- State machine states:
  - IDLE: after reset, one cycle, no request.
  - FETCH: request outstanding.
  - BUFWAIT: skid buffer full, no request.
  - DROP: outstanding request must be discarded.
  - HALTED: terminal until reset.
- Reset values:
  - State goes to IDLE.
  - pc=RESET_PC; i_readM=0; i_address=0.
  - if_id_valid=0; if_id_inst=0; if_id_pc1=0; buffer empty.
- Output timing:
  - i_readM and i_address are registered.
  - The first request is visible one cycle after reset deasserts (IDLE->FETCH).
- Memory contract:
  - Latency is 1 or more cycles.
  - i_readM and i_address are held from issue through the i_ready cycle inclusive.
  - A new request may start on the following edge; with 1-cycle memory the throughput is 1 instruction per cycle.
- FETCH with i_ready=1:
  - stall=0: IF/ID <= {i_data, pc+1, valid=1}; pc <= pc+1; next request at pc+1.
  - stall=1: buffer <= {i_data, pc+1}; pc <= pc+1; go to BUFWAIT with i_readM=0.
- FETCH with i_ready=0 and stall=0: IF/ID valid <= 0 (bubble).
  - If stall=1, IF/ID holds.
- BUFWAIT: when stall drops, buffer moves to IF/ID (valid=1) and the fetch of pc is reissued.
- Redirect (highest priority after reset):
  - if_id_valid <= 0; buffer cleared; pc <= redirect_target.
  - If a request is outstanding and i_ready=0: go to DROP, keep the old address and i_readM high until i_ready, discard the data, then go to FETCH at the target.
  - If i_ready=1 in the redirect cycle: the data is discarded and the next request issues to the target.
  - Redirect overrides stall.
- Halt:
  - if_id_valid <= 0; buffer cleared.
  - Any outstanding request completes through DROP, then the state goes to HALTED.
  - HALTED: i_readM=0, IF/ID frozen invalid, PC frozen.
  - Halt while stall=1 is ignored.
- Priority when events coincide: reset > redirect > halt > stall > normal.
  - Redirect+halt in the same cycle means redirect (the HLT is younger and is flushed).
- Arithmetic: pc+1 is modulo 2^WORD_W (16'hFFFF -> 16'h0000).
- opcode and func_code are combinational slices of if_id_inst.
- Reset mid-request: the memory response is ignored, because state is IDLE and i_readM=0.

Decomposition:
- Shared package holds:
  - WORD_W;
  - fetch state encoding (IDLE, FETCH, BUFWAIT, DROP, HALTED);
  - instruction field slice constants (OPCODE_MSB/LSB, FUNC_MSB/LSB), shared with the control unit.
- One natural sub-module: if_id_reg, holding the IF/ID register with load/hold/flush controls.

Test Plan:
1. Reset then 1-cycle memory, i_data=16'h4123 at addr 0, 16'hF01C at addr 1:
   - i_readM rises one cycle after reset release.
   - if_id_inst=4123, pc1=0001, then F01C, pc1=0002, on consecutive cycles.
   - opcode=4, then 15 with func_code=28.
2. stall=1 for 3 cycles while the response for addr 2 arrives:
   - IF/ID holds; data is buffered; i_readM=0 during BUFWAIT.
   - On release the buffered inst appears in IF/ID; the next request is addr 3.
   - No instruction is lost or duplicated.
3. 3-cycle memory latency, redirect_valid=1 with target 16'h0040 in the 2nd wait cycle:
   - i_address stays at the old value until i_ready, and that data is dropped.
   - The next request is addr 0040; if_id_valid=0 throughout.
4. halt=1 and redirect_valid=1 (target 0010) in the same cycle:
   - The redirect wins, no HALTED state; fetch resumes at 0010.
5. halt=1 alone:
   - Enters HALTED; i_readM stays 0 for 10+ cycles; if_id_valid=0.
   - Reset_n=1 for one cycle returns the block to IDLE and pc=0.
6. pc=16'hFFFF fetch:
   - if_id_pc1=0000; the next request address is 0000.
